sae: RTL and testbench

Simple asymmetric encryption engine (SAE) operating on single 8-bit characters. One instance serves one party. Per request it generates a public key from a private key, encrypts a plaintext character with a public key, or decrypts a ciphertext character with a private key. All arithmetic is modulo N = 127. Results are registered, and invalid inputs are reported on dedicated error flags.

---
 rtl/sae.sv | 87 ++++++++
 tb/tb_sae.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sae.sv
// Single-character asymmetric encryption engine, modulus 127.
// One registered result per accepted request: key generation, encryption or decryption.
module sae (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [7:0] data_input,
    input  logic [7:0] key_input,
    input  logic       inputs_valid,
    output logic [7:0] data_output,
    output logic       output_ready,
    output logic       err_invalid_ptxt_char,
    output logic       err_invalid_seckey,
    output logic       err_invalid_ctxt_char
);

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_KEYGEN = 2'b01,
        MODE_ENC    = 2'b10,
        MODE_DEC    = 2'b11
    } mode_e;

    typedef struct packed {
        logic [7:0] data;
        logic       ready;
        logic       err_ptxt;
        logic       err_key;
        logic       err_ctxt;
    } rsp_t;

    rsp_t       rsp_q, rsp_d;
    logic       key_bad, char_bad;
    logic [8:0] sum9;
    logic [7:0] sum_mod;

    assign key_bad  = (key_input == 8'd0) || (key_input >= 8'd127);
    assign char_bad = (data_input >= 8'd127);
    assign sum9     = {1'b0, data_input} + {1'b0, key_input};
    // Adding 129 modulo 256 is the same as subtracting 127 in the low byte.
    assign sum_mod  = sum9[7:0] + ((sum9 >= 9'd127) ? 8'd129 : 8'd0);

    always_comb begin
        rsp_d = '0;
        case (mode_e'(mode))
            MODE_KEYGEN: begin
                rsp_d.err_key = key_bad;
                if (!key_bad) begin
                    rsp_d.data  = 8'd127 - key_input;
                    rsp_d.ready = 1'b1;
                end
            end
            MODE_ENC: begin
                rsp_d.err_key  = key_bad;
                rsp_d.err_ptxt = char_bad;
                if (!key_bad && !char_bad) begin
                    rsp_d.data  = sum_mod;
                    rsp_d.ready = 1'b1;
                end
            end
            MODE_DEC: begin
                rsp_d.err_key  = key_bad;
                rsp_d.err_ctxt = char_bad;
                if (!key_bad && !char_bad) begin
                    rsp_d.data  = sum_mod;
                    rsp_d.ready = 1'b1;
                end
            end
            default: rsp_d = '0;
        endcase
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            rsp_q <= '0;
        else if (inputs_valid)
            rsp_q <= rsp_d;
    end

    assign data_output           = rsp_q.data;
    assign output_ready          = rsp_q.ready;
    assign err_invalid_ptxt_char = rsp_q.err_ptxt;
    assign err_invalid_seckey    = rsp_q.err_key;
    assign err_invalid_ctxt_char = rsp_q.err_ctxt;

endmodule

// File: tb/tb_sae.sv
// Self-checking bench for sae: directed scenarios plus randomized requests
// compared against an arithmetic reference model.
module tb_sae;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] data_input;
    logic [7:0] key_input;
    logic       inputs_valid;
    logic [7:0] data_output;
    logic       output_ready;
    logic       err_invalid_ptxt_char;
    logic       err_invalid_seckey;
    logic       err_invalid_ctxt_char;

    int checks = 0;
    int errors = 0;

    sae dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .mode                  (mode),
        .data_input            (data_input),
        .key_input             (key_input),
        .inputs_valid          (inputs_valid),
        .data_output           (data_output),
        .output_ready          (output_ready),
        .err_invalid_ptxt_char (err_invalid_ptxt_char),
        .err_invalid_seckey    (err_invalid_seckey),
        .err_invalid_ctxt_char (err_invalid_ctxt_char)
    );

    always #5 clk = ~clk;

    // {data[7:0], ready, err_ptxt, err_key, err_ctxt}
    wire [11:0] obs = {data_output, output_ready, err_invalid_ptxt_char,
                       err_invalid_seckey, err_invalid_ctxt_char};

    function automatic logic [11:0] model(input int m, input int d, input int k);
        bit kbad, cbad;
        int res;
        kbad = (k < 1) || (k > 126);
        cbad = (d > 126);
        case (m)
            1: begin
                if (kbad) return {8'h00, 4'b0010};
                res = 127 - k;
                return {res[7:0], 4'b1000};
            end
            2: begin
                if (kbad || cbad) return {8'h00, 1'b0, cbad, kbad, 1'b0};
                res = (d + k) % 127;
                return {res[7:0], 4'b1000};
            end
            3: begin
                if (kbad || cbad) return {8'h00, 1'b0, 1'b0, kbad, cbad};
                res = (d + k) % 127;
                return {res[7:0], 4'b1000};
            end
            default: return 12'h000;
        endcase
    endfunction

    task automatic req(input logic [1:0] m, input logic [7:0] d, input logic [7:0] k);
        @(negedge clk);
        mode = m; data_input = d; key_input = k; inputs_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic [1:0] m, input logic [7:0] d, input logic [7:0] k);
        @(negedge clk);
        mode = m; data_input = d; key_input = k; inputs_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; mode = 2'b00; data_input = 8'h00; key_input = 8'h00; inputs_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== 12'h000) begin
            errors++; $display("FAIL reset_state obs=%h exp=%h", obs, 12'h000);
        end
        @(negedge clk); rst_n = 1'b0;
    endtask

    task automatic test_keygen;
        req(2'b01, 8'h00, 8'h05);
        checks++;
        if (obs !== {8'h7A, 4'b1000}) begin
            errors++; $display("FAIL keygen obs=%h exp=%h", obs, {8'h7A, 4'b1000});
        end
        for (int i = 0; i < 3; i++) begin
            idle_cycle(2'(i), 8'($urandom), 8'($urandom));
            checks++;
            if (obs !== {8'h7A, 4'b1000}) begin
                errors++; $display("FAIL keygen_hold%0d obs=%h exp=%h", i, obs, {8'h7A, 4'b1000});
            end
        end
    endtask

    task automatic test_encrypt;
        req(2'b10, 8'h41, 8'h7A);
        checks++;
        if (obs !== {8'h3C, 4'b1000}) begin
            errors++; $display("FAIL enc_A obs=%h exp=%h", obs, {8'h3C, 4'b1000});
        end
        req(2'b10, 8'h04, 8'h7A);
        checks++;
        if (obs !== {8'h7E, 4'b1000}) begin
            errors++; $display("FAIL enc_nowrap obs=%h exp=%h", obs, {8'h7E, 4'b1000});
        end
        req(2'b10, 8'h05, 8'h7A);
        checks++;
        if (obs !== {8'h00, 4'b1000}) begin
            errors++; $display("FAIL enc_wrap127 obs=%h exp=%h", obs, {8'h00, 4'b1000});
        end
    endtask

    task automatic test_decrypt;
        string txt = "Hello, World! SAE 0123 ~{}|";
        logic [7:0] ct[$];
        logic [7:0] c;
        req(2'b11, 8'h3C, 8'h05);
        checks++;
        if (obs !== {8'h41, 4'b1000}) begin
            errors++; $display("FAIL dec_A obs=%h exp=%h", obs, {8'h41, 4'b1000});
        end
        for (int i = 0; i < txt.len(); i++) begin
            c = txt[i];
            req(2'b10, c, 8'h7A);
            checks++;
            if (!output_ready || data_output[7] !== 1'b0) begin
                errors++; $display("FAIL enc_text%0d obs=%h", i, obs);
            end
            ct.push_back(data_output);
        end
        for (int i = 0; i < txt.len(); i++) begin
            c = txt[i];
            req(2'b11, ct[i], 8'h05);
            checks++;
            if (obs !== {c, 4'b1000}) begin
                errors++; $display("FAIL roundtrip%0d obs=%h exp=%h", i, obs, {c, 4'b1000});
            end
        end
    endtask

    task automatic test_key_errors;
        logic [7:0] keys[3];
        keys[0] = 8'h00; keys[1] = 8'h7F; keys[2] = 8'hFF;
        req(2'b01, 8'h10, 8'h00);
        checks++;
        if (obs !== {8'h00, 4'b0010}) begin
            errors++; $display("FAIL keyerr_gen obs=%h exp=%h", obs, {8'h00, 4'b0010});
        end
        for (int i = 0; i < 3; i++) begin
            req(2'b10, 8'h41, keys[i]);
            checks++;
            if (obs !== {8'h00, 4'b0010}) begin
                errors++; $display("FAIL keyerr_enc k=%h obs=%h exp=%h", keys[i], obs, {8'h00, 4'b0010});
            end
            req(2'b11, 8'h3C, keys[i]);
            checks++;
            if (obs !== {8'h00, 4'b0010}) begin
                errors++; $display("FAIL keyerr_dec k=%h obs=%h exp=%h", keys[i], obs, {8'h00, 4'b0010});
            end
        end
        req(2'b01, 8'h00, 8'h7E);
        checks++;
        if (obs !== {8'h01, 4'b1000}) begin
            errors++; $display("FAIL keygen_126 obs=%h exp=%h", obs, {8'h01, 4'b1000});
        end
    endtask

    task automatic test_char_errors;
        req(2'b10, 8'h7F, 8'h7A);
        checks++;
        if (obs !== {8'h00, 4'b0100}) begin
            errors++; $display("FAIL ptxt_err obs=%h exp=%h", obs, {8'h00, 4'b0100});
        end
        req(2'b11, 8'h80, 8'h05);
        checks++;
        if (obs !== {8'h00, 4'b0001}) begin
            errors++; $display("FAIL ctxt_err obs=%h exp=%h", obs, {8'h00, 4'b0001});
        end
        req(2'b10, 8'hC0, 8'h00);
        checks++;
        if (obs !== {8'h00, 4'b0110}) begin
            errors++; $display("FAIL both_err obs=%h exp=%h", obs, {8'h00, 4'b0110});
        end
        req(2'b10, 8'h7E, 8'h7E);
        checks++;
        if (obs !== {8'h7D, 4'b1000}) begin
            errors++; $display("FAIL clear_after_err obs=%h exp=%h", obs, {8'h7D, 4'b1000});
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] exp;
        int m, d, k;
        for (int i = 0; i < 300; i++) begin
            m = $urandom_range(0, 3);
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 126);
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(1, 126);
            req(2'(m), 8'(d), 8'(k));
            exp = model(m, d, k);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL random%0d m=%0d d=%h k=%h obs=%h exp=%h", i, m, d, k, obs, exp);
            end
        end
    endtask

    task automatic test_async_reset;
        req(2'b01, 8'h00, 8'h20);
        @(negedge clk);
        inputs_valid = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== 12'h000) begin
            errors++; $display("FAIL async_reset obs=%h exp=%h", obs, 12'h000);
        end
        req(2'b10, 8'h41, 8'h7A);
        checks++;
        if (obs !== 12'h000) begin
            errors++; $display("FAIL reset_hold obs=%h exp=%h", obs, 12'h000);
        end
        @(negedge clk); rst_n = 1'b0;
        req(2'b10, 8'h41, 8'h7A);
        checks++;
        if (obs !== {8'h3C, 4'b1000}) begin
            errors++; $display("FAIL post_reset obs=%h exp=%h", obs, {8'h3C, 4'b1000});
        end
    endtask

    task automatic test_idle;
        req(2'b01, 8'h00, 8'h33);
        req(2'b00, 8'h41, 8'h05);
        checks++;
        if (obs !== 12'h000) begin
            errors++; $display("FAIL idle_clear obs=%h exp=%h", obs, 12'h000);
        end
        req(2'b11, 8'h80, 8'h00);
        req(2'b00, 8'h00, 8'h00);
        checks++;
        if (obs !== 12'h000) begin
            errors++; $display("FAIL idle_clear_err obs=%h exp=%h", obs, 12'h000);
        end
    endtask

    initial begin
        test_reset;
        test_keygen;
        test_encrypt;
        test_decrypt;
        test_key_errors;
        test_char_errors;
        test_back_to_back;
        test_async_reset;
        test_idle;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
